// File: rtl/multi_cycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcode/funct
// constants, ALU function classes, datapath select codes and the decoder result.
package multi_cycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JREG     = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_BR  = 3'b001;
  localparam logic [2:0] ALU_R   = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SEL_NONE   = 2'b00;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_REG   = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BOFF  = 2'b11;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JMP  = 2'b10;
  localparam logic [1:0] PCSRC_REG  = 2'b11;
  localparam logic [1:0] DST_RT     = 2'b00;
  localparam logic [1:0] DST_RD     = 2'b01;
  localparam logic [1:0] DST_RA     = 2'b10;
  localparam logic [1:0] WB_ALU     = 2'b00;
  localparam logic [1:0] WB_MEM     = 2'b01;
  localparam logic [1:0] WB_PC4     = 2'b10;

  typedef enum logic [2:0] {
    C_MEM, C_RTYPE, C_ITYPE, C_BRANCH, C_JUMP, C_JREG, C_ILLEGAL
  } iclass_e;

  typedef struct packed {
    iclass_e    cls;
    logic       store;
    logic       link;
    logic       shift;
    logic       lui;
    logic       ext;
    logic [3:0] alu_op;
  } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational OpCode/Funct classification: dispatch class, sub-flags,
// immediate extension mode and ALU function class.
module mc_decode
  import multi_cycle_control_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output dec_t       o_dec
);

  always_comb begin
    o_dec           = '0;
    o_dec.cls       = C_ILLEGAL;
    o_dec.alu_op[3] = i_opcode[0];
    case (i_opcode)
      OP_LW, OP_SW: begin
        o_dec.cls   = C_MEM;
        o_dec.store = (i_opcode == OP_SW);
        o_dec.ext   = 1'b1;
      end
      OP_RTYPE: begin
        o_dec.cls          = (i_funct == FN_JR || i_funct == FN_JALR) ? C_JREG : C_RTYPE;
        o_dec.link         = (i_funct == FN_JALR);
        o_dec.shift        = (i_funct inside {FN_SLL, FN_SRL, FN_SRA});
        o_dec.alu_op[2:0]  = ALU_R;
      end
      OP_ADDI, OP_ADDIU: begin
        o_dec.cls = C_ITYPE;
        o_dec.ext = 1'b1;
      end
      OP_SLTI: begin
        o_dec.cls         = C_ITYPE;
        o_dec.ext         = 1'b1;
        o_dec.alu_op[2:0] = ALU_SLT;
      end
      OP_SLTIU: begin
        o_dec.cls         = C_ITYPE;
        o_dec.alu_op[2:0] = ALU_SLT;
      end
      OP_ANDI: begin
        o_dec.cls         = C_ITYPE;
        o_dec.alu_op[2:0] = ALU_AND;
      end
      OP_LUI: begin
        o_dec.cls = C_ITYPE;
        o_dec.lui = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        o_dec.cls         = C_BRANCH;
        o_dec.ext         = 1'b1;
        o_dec.alu_op[2:0] = ALU_BR;
      end
      OP_J:    o_dec.cls = C_JUMP;
      OP_JAL: begin
        o_dec.cls  = C_JUMP;
        o_dec.link = 1'b1;
      end
      default: o_dec.cls = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control FSM: one state register plus a memory wait counter;
// controls decode combinationally from the current state, forced to zero under reset.
module multi_cycle_control
  import multi_cycle_control_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int ALUOP_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OpCode,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  output logic               PCWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic               ExtOp,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [3:0]         State,
  output logic               Illegal
);

  localparam logic [2:0] LP_WAIT = 3'(MEM_WAIT);

  state_e     r_state;
  logic [2:0] r_cnt;
  dec_t       w_dec;
  logic       w_mem;
  logic       w_last;

  mc_decode u_decode (
    .i_opcode (OpCode),
    .i_funct  (Funct),
    .o_dec    (w_dec)
  );

  // The counter is zero outside memory states, so every memory state starts at 0.
  assign w_mem  = (r_state inside {S_FETCH, S_MEM_RD, S_MEM_WR});
  assign w_last = (r_cnt == LP_WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      r_cnt <= (w_mem && !w_last) ? r_cnt + 3'd1 : 3'd0;
      case (r_state)
        S_FETCH:    if (w_last) r_state <= S_DECODE;
        S_DECODE: begin
          case (w_dec.cls)
            C_MEM:    r_state <= S_MEM_ADDR;
            C_RTYPE:  r_state <= S_EXEC_R;
            C_ITYPE:  r_state <= S_EXEC_I;
            C_BRANCH: r_state <= S_BRANCH;
            C_JUMP:   r_state <= S_JUMP;
            C_JREG:   r_state <= S_JREG;
            default:  r_state <= S_ILLEGAL;
          endcase
        end
        S_MEM_ADDR: r_state <= w_dec.store ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   if (w_last) r_state <= S_MEM_WB;
        S_MEM_WR:   if (w_last) r_state <= S_FETCH;
        S_EXEC_R:   r_state <= S_R_WB;
        S_EXEC_I:   r_state <= S_I_WB;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = SEL_NONE;
    MemtoReg = SEL_NONE;
    ALUSrcA  = SEL_NONE;
    ALUSrcB  = SEL_NONE;
    PCSource = SEL_NONE;
    ExtOp    = 1'b0;
    ALUOp    = '0;
    Illegal  = 1'b0;
    State    = 4'(S_FETCH);
    if (!reset) begin
      State = r_state;
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = w_last;
          PCWrite = w_last;
        end
        S_DECODE: begin
          ALUSrcA = SRCA_PC;
          ALUSrcB = SRCB_BOFF;
          ExtOp   = w_dec.ext;
        end
        S_MEM_ADDR: begin
          ALUSrcA = SRCA_REG;
          ALUSrcB = SRCB_IMM;
          ExtOp   = w_dec.ext;
          ALUOp   = ALUOP_W'(w_dec.alu_op);
        end
        S_MEM_RD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEM_WR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_MEM_WB: begin
          RegWrite = 1'b1;
          RegDst   = DST_RT;
          MemtoReg = WB_MEM;
        end
        S_EXEC_R: begin
          ALUSrcA = w_dec.shift ? SRCA_SHAMT : SRCA_REG;
          ALUSrcB = SRCB_REG;
          ALUOp   = ALUOP_W'(w_dec.alu_op);
        end
        S_R_WB: begin
          RegWrite = 1'b1;
          RegDst   = DST_RD;
          MemtoReg = WB_ALU;
        end
        S_EXEC_I: begin
          // lui ignores the register operand; the ALU builds the upper immediate.
          ALUSrcA = w_dec.lui ? SEL_NONE : SRCA_REG;
          ALUSrcB = SRCB_IMM;
          ExtOp   = w_dec.ext;
          ALUOp   = ALUOP_W'(w_dec.alu_op);
        end
        S_I_WB: begin
          RegWrite = 1'b1;
          RegDst   = DST_RT;
          MemtoReg = WB_ALU;
        end
        S_BRANCH: begin
          ALUSrcA  = SRCA_REG;
          ALUSrcB  = SRCB_REG;
          ExtOp    = w_dec.ext;
          ALUOp    = ALUOP_W'(w_dec.alu_op);
          PCSource = PCSRC_BR;
          PCWrite  = Zero ^ OpCode[0];
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_JMP;
          if (w_dec.link) begin
            RegWrite = 1'b1;
            RegDst   = DST_RA;
            MemtoReg = WB_PC4;
          end
        end
        S_JREG: begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_REG;
          if (w_dec.link) begin
            RegWrite = 1'b1;
            RegDst   = DST_RD;
            MemtoReg = WB_PC4;
          end
        end
        S_ILLEGAL: Illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: two instances (MEM_WAIT 0 and 3) driven from a
// per-instruction expected-cycle scoreboard.
module tb_multi_cycle_control;
  import multi_cycle_control_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic pcw, iord, mrd, mwr, irw, rgw, ill, ext;
    logic [1:0] rdst, m2r, sa, sb, pcs;
    logic [4:0] alu;
  } rec_t;

  logic clk = 1'b0;
  logic rst0 = 1'b1, rst3 = 1'b1;
  logic [5:0] op = '0, fn = '0;
  logic zero = 1'b0;

  logic d0_pcw, d0_iord, d0_mrd, d0_mwr, d0_irw, d0_rgw, d0_ext, d0_ill;
  logic [1:0] d0_rdst, d0_m2r, d0_sa, d0_sb, d0_pcs;
  logic [3:0] d0_alu, d0_st;
  logic d3_pcw, d3_iord, d3_mrd, d3_mwr, d3_irw, d3_rgw, d3_ext, d3_ill;
  logic [1:0] d3_rdst, d3_m2r, d3_sa, d3_sb, d3_pcs;
  logic [4:0] d3_alu;
  logic [3:0] d3_st;

  rec_t obs0, obs3, obs, exp_r;
  rec_t sb_q[$];
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  multi_cycle_control #(.MEM_WAIT(0), .ALUOP_W(4)) dut0 (
    .clk(clk), .reset(rst0), .OpCode(op), .Funct(fn), .Zero(zero),
    .PCWrite(d0_pcw), .IorD(d0_iord), .MemRead(d0_mrd), .MemWrite(d0_mwr),
    .IRWrite(d0_irw), .RegWrite(d0_rgw), .RegDst(d0_rdst), .MemtoReg(d0_m2r),
    .ALUSrcA(d0_sa), .ALUSrcB(d0_sb), .PCSource(d0_pcs), .ExtOp(d0_ext),
    .ALUOp(d0_alu), .State(d0_st), .Illegal(d0_ill));

  multi_cycle_control #(.MEM_WAIT(3), .ALUOP_W(5)) dut3 (
    .clk(clk), .reset(rst3), .OpCode(op), .Funct(fn), .Zero(zero),
    .PCWrite(d3_pcw), .IorD(d3_iord), .MemRead(d3_mrd), .MemWrite(d3_mwr),
    .IRWrite(d3_irw), .RegWrite(d3_rgw), .RegDst(d3_rdst), .MemtoReg(d3_m2r),
    .ALUSrcA(d3_sa), .ALUSrcB(d3_sb), .PCSource(d3_pcs), .ExtOp(d3_ext),
    .ALUOp(d3_alu), .State(d3_st), .Illegal(d3_ill));

  assign obs0 = {d0_st, d0_pcw, d0_iord, d0_mrd, d0_mwr, d0_irw, d0_rgw, d0_ill, d0_ext,
                 d0_rdst, d0_m2r, d0_sa, d0_sb, d0_pcs, 1'b0, d0_alu};
  assign obs3 = {d3_st, d3_pcw, d3_iord, d3_mrd, d3_mwr, d3_irw, d3_rgw, d3_ill, d3_ext,
                 d3_rdst, d3_m2r, d3_sa, d3_sb, d3_pcs, d3_alu};

  function automatic rec_t fetch_rec(input bit last);
    rec_t r;
    r = '0; r.st = S_FETCH; r.mrd = 1'b1; r.sb = 2'b01;
    r.irw = last; r.pcw = last;
    return r;
  endfunction

  // Expected per-cycle control word for one instruction, from FETCH to its last state.
  task automatic expect_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                              input int w, input bit trailer);
    rec_t r;
    logic e;
    logic [4:0] a;
    e = (o inside {6'h23, 6'h2b, 6'h08, 6'h09, 6'h0a, 6'h04, 6'h05});
    case (o)
      6'h00:        a = 5'b00010;
      6'h04, 6'h05: a = 5'b00001;
      6'h0c:        a = 5'b00100;
      6'h0a, 6'h0b: a = 5'b00101;
      default:      a = 5'b00000;
    endcase
    a[3] = o[0];
    for (int i = 0; i <= w; i++) sb_q.push_back(fetch_rec(i == w));
    r = '0; r.st = S_DECODE; r.sb = 2'b11; r.ext = e; sb_q.push_back(r);
    r = '0;
    case (o)
      6'h23, 6'h2b: begin
        r.st = S_MEM_ADDR; r.sa = 2'b01; r.sb = 2'b10; r.ext = e; r.alu = a; sb_q.push_back(r);
        for (int i = 0; i <= w; i++) begin
          r = '0; r.st = (o == 6'h23) ? S_MEM_RD : S_MEM_WR; r.iord = 1'b1;
          r.mrd = (o == 6'h23); r.mwr = (o == 6'h2b); sb_q.push_back(r);
        end
        if (o == 6'h23) begin
          r = '0; r.st = S_MEM_WB; r.rgw = 1'b1; r.m2r = 2'b01; sb_q.push_back(r);
        end
      end
      6'h00: begin
        if (f == 6'h08 || f == 6'h09) begin
          r.st = S_JREG; r.pcw = 1'b1; r.pcs = 2'b11;
          if (f == 6'h09) begin r.rgw = 1'b1; r.rdst = 2'b01; r.m2r = 2'b10; end
          sb_q.push_back(r);
        end else begin
          r.st = S_EXEC_R; r.sa = (f inside {6'h00, 6'h02, 6'h03}) ? 2'b10 : 2'b01;
          r.alu = a; sb_q.push_back(r);
          r = '0; r.st = S_R_WB; r.rgw = 1'b1; r.rdst = 2'b01; sb_q.push_back(r);
        end
      end
      6'h0f, 6'h08, 6'h09, 6'h0c, 6'h0a, 6'h0b: begin
        r.st = S_EXEC_I; r.sa = (o == 6'h0f) ? 2'b00 : 2'b01; r.sb = 2'b10;
        r.ext = e; r.alu = a; sb_q.push_back(r);
        r = '0; r.st = S_I_WB; r.rgw = 1'b1; sb_q.push_back(r);
      end
      6'h04, 6'h05: begin
        r.st = S_BRANCH; r.sa = 2'b01; r.ext = e; r.alu = a; r.pcs = 2'b01;
        r.pcw = z ^ o[0]; sb_q.push_back(r);
      end
      6'h02, 6'h03: begin
        r.st = S_JUMP; r.pcw = 1'b1; r.pcs = 2'b10;
        if (o == 6'h03) begin r.rgw = 1'b1; r.rdst = 2'b10; r.m2r = 2'b10; end
        sb_q.push_back(r);
      end
      default: begin
        r.st = S_ILLEGAL; r.ill = 1'b1; sb_q.push_back(r);
      end
    endcase
    if (trailer) sb_q.push_back(fetch_rec(w == 0));
  endtask

  task automatic launch(input bit w3, input logic [5:0] o, input logic [5:0] f,
                        input logic z, input bit trailer);
    op = o; fn = f; zero = z;
    expect_instr(o, f, z, w3 ? 3 : 0, trailer);
    if (w3) rst3 = 1'b0; else rst0 = 1'b0;
  endtask

  task automatic park();
    rst0 = 1'b1; rst3 = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    op = 6'h23;
    @(negedge clk); #1;
    n_chk++;
    if (obs0 !== '0) $display("FAIL reset_w0: got %h want 0", obs0); else n_pass++;
    n_chk++;
    if (obs3 !== '0) $display("FAIL reset_w3: got %h want 0", obs3); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_lw();
    launch(1'b0, 6'h23, 6'h00, 1'b0, 1'b1);
    for (int k = 0; sb_q.size() > 0; k++) begin
      exp_r = sb_q.pop_front(); #1; obs = obs0; n_chk++;
      if (obs !== exp_r) $display("FAIL lw cyc%0d: got %h want %h", k + 1, obs, exp_r);
      else n_pass++;
      @(negedge clk);
    end
    park();
  endtask

  task automatic test_sw_wait();
    launch(1'b1, 6'h2b, 6'h00, 1'b0, 1'b1);
    for (int k = 0; sb_q.size() > 0; k++) begin
      exp_r = sb_q.pop_front(); #1; obs = obs3; n_chk++;
      if (obs !== exp_r) $display("FAIL sw_wait3 cyc%0d: got %h want %h", k + 1, obs, exp_r);
      else n_pass++;
      @(negedge clk);
    end
    park();
  endtask

  // Table-driven run of single instructions: {use_wait3, opcode, funct, zero}.
  task automatic test_table(input string name, input logic [13:0] tbl[]);
    foreach (tbl[t]) begin
      launch(tbl[t][13], tbl[t][12:7], tbl[t][6:1], tbl[t][0], 1'b1);
      for (int k = 0; sb_q.size() > 0; k++) begin
        exp_r = sb_q.pop_front(); #1; obs = tbl[t][13] ? obs3 : obs0; n_chk++;
        if (obs !== exp_r)
          $display("FAIL %s op%h fn%h z%0d cyc%0d: got %h want %h", name, tbl[t][12:7],
                   tbl[t][6:1], tbl[t][0], k + 1, obs, exp_r);
        else n_pass++;
        @(negedge clk);
      end
      park();
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] seq [6];
    seq = '{{6'h23, 6'h00, 1'b0}, {6'h2b, 6'h00, 1'b0}, {6'h04, 6'h00, 1'b1},
            {6'h03, 6'h00, 1'b0}, {6'h3f, 6'h00, 1'b0}, {6'h00, 6'h20, 1'b0}};
    foreach (seq[s]) begin
      launch(1'b0, seq[s][12:7], seq[s][6:1], seq[s][0], s == 5);
      for (int k = 0; sb_q.size() > 0; k++) begin
        exp_r = sb_q.pop_front(); #1; obs = obs0; n_chk++;
        if (obs !== exp_r)
          $display("FAIL b2b instr%0d cyc%0d: got %h want %h", s, k + 1, obs, exp_r);
        else n_pass++;
        @(negedge clk);
      end
    end
    park();
  endtask

  task automatic test_reset_mid();
    launch(1'b1, 6'h23, 6'h00, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      exp_r = sb_q.pop_front(); #1; obs = obs3; n_chk++;
      if (obs !== exp_r) $display("FAIL rstmid pre cyc%0d: got %h want %h", k + 1, obs, exp_r);
      else n_pass++;
      if (k != 8) @(negedge clk);
    end
    sb_q.delete();
    rst3 = 1'b1; #1;
    n_chk++;
    if (obs3 !== '0) $display("FAIL rstmid reset_cycle: got %h want 0", obs3); else n_pass++;
    @(negedge clk); #1;
    n_chk++;
    if (obs3 !== '0) $display("FAIL rstmid after_edge: got %h want 0", obs3); else n_pass++;
    @(negedge clk);
    launch(1'b1, 6'h2b, 6'h00, 1'b0, 1'b1);
    for (int k = 0; sb_q.size() > 0; k++) begin
      exp_r = sb_q.pop_front(); #1; obs = obs3; n_chk++;
      if (obs !== exp_r) $display("FAIL rstmid post cyc%0d: got %h want %h", k + 1, obs, exp_r);
      else n_pass++;
      @(negedge clk);
    end
    park();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [13:0] rt[], it[], br[], jp[], il[];
    repeat (3) @(negedge clk);
    test_reset();
    test_lw();
    test_sw_wait();
    rt = '{{1'b0, 6'h00, 6'h20, 1'b0}, {1'b0, 6'h00, 6'h00, 1'b0}, {1'b0, 6'h00, 6'h02, 1'b0},
           {1'b0, 6'h00, 6'h03, 1'b0}, {1'b0, 6'h00, 6'h2a, 1'b0}, {1'b0, 6'h00, 6'h08, 1'b0},
           {1'b0, 6'h00, 6'h09, 1'b0}, {1'b1, 6'h00, 6'h09, 1'b0}};
    test_table("rtype", rt);
    it = '{{1'b0, 6'h0f, 6'h00, 1'b0}, {1'b0, 6'h08, 6'h00, 1'b0}, {1'b0, 6'h09, 6'h00, 1'b0},
           {1'b0, 6'h0c, 6'h00, 1'b0}, {1'b0, 6'h0a, 6'h00, 1'b0}, {1'b0, 6'h0b, 6'h00, 1'b0},
           {1'b1, 6'h0b, 6'h00, 1'b0}};
    test_table("itype", it);
    br = '{{1'b0, 6'h04, 6'h00, 1'b1}, {1'b0, 6'h04, 6'h00, 1'b0},
           {1'b0, 6'h05, 6'h00, 1'b1}, {1'b0, 6'h05, 6'h00, 1'b0}};
    test_table("branch", br);
    jp = '{{1'b0, 6'h02, 6'h00, 1'b0}, {1'b0, 6'h03, 6'h00, 1'b0}, {1'b1, 6'h03, 6'h00, 1'b0}};
    test_table("jump", jp);
    il = '{{1'b0, 6'h3f, 6'h00, 1'b0}, {1'b0, 6'h01, 6'h00, 1'b0}, {1'b1, 6'h3f, 6'h00, 1'b0}};
    test_table("illegal", il);
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 Parameter MEM_WAIT, default 0: extra wait cycles per memory access; legal range 0..7.
REQ-002 Parameter ALUOP_W, default 4: ALUOp width; legal range ≥4, upper bits zero.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 OpCode  in  6  instruction[31:26], taken from the instruction register.
REQ-006 Funct  in  6  instruction[5:0].
REQ-007 Zero  in  1  ALU zero flag.
REQ-008 PCWrite  out  1  PC load enable; includes the resolved branch condition.
REQ-009 IorD  out  1  memory address select: 0=PC, 1=ALUOut.
REQ-010 MemRead / MemWrite / IRWrite / RegWrite  out  1 each  strobes.
REQ-011 RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource  out  2 each  datapath selects.
REQ-012 ExtOp  out  1  1=sign-extend, 0=zero-extend the immediate.
REQ-013 ALUOp  out  ALUOP_W  ALU function class.
REQ-014 State  out  4  current FSM state (debug).
REQ-015 Illegal  out  1  one-cycle pulse on an undecodable instruction.

Function
REQ-016 FSM states: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, JREG, ILLEGAL.
REQ-017 Supported instructions: lw 23, sw 2b, lui 0f, addi 08, addiu 09, andi 0c, slti 0a, sltiu 0b, beq 04, bne 05, j 02, jal 03, R-type 00 including jr (Funct 08), jalr (Funct 09), and sll/srl/sra (Funct 00/02/03).
REQ-018 FETCH: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01 (PC+4). IRWrite and PCWrite assert only in the final cycle. Holds 1+MEM_WAIT cycles, then goes to DECODE.
REQ-019 DECODE: computes the branch target (ALUSrcB=11); one cycle; dispatches on OpCode/Funct.
REQ-020 DECODE transitions: lw/sw→MEM_ADDR; R-type other than jr/jalr→EXEC_R; I-type ALU→EXEC_I; beq/bne→BRANCH; j/jal→JUMP; jr/jalr→JREG; any other opcode→ILLEGAL.
REQ-021 MEM_ADDR→MEM_RD (lw) or MEM_WR (sw).
REQ-022 MEM_RD and MEM_WR hold 1+MEM_WAIT cycles with IorD=1. MEM_WR→FETCH. MEM_RD→MEM_WB, which writes with RegDst=00 and MemtoReg=01.
REQ-023 EXEC_R→R_WB (RegDst=01, MemtoReg=00). Shifts set ALUSrcA=10 (shamt).
REQ-024 EXEC_I→I_WB (RegDst=00). lui uses ALUSrcB=10 with MemtoReg=00; the ALU performs the upper-immediate operation.
REQ-025 BRANCH: PCWrite = Zero XOR OpCode[0]; PCSource=01.
REQ-026 JUMP: PCWrite=1, PCSource=10. jal also asserts RegWrite with RegDst=10 ($31) and MemtoReg=10 (PC+4).
REQ-027 JREG: PCWrite=1, PCSource=11. jalr also asserts RegWrite with RegDst=01 and MemtoReg=10.
REQ-028 ILLEGAL: Illegal=1, no write strobes asserted; next state FETCH.
REQ-029 All writeback states, BRANCH, JUMP and JREG return to FETCH.
REQ-030 ExtOp=1 for lw, sw, addi, addiu, slti, beq, bne; 0 otherwise (lui and andi zero-extend).
REQ-031 ALUOp[2:0]: 010 R-type, 001 branch, 100 andi, 101 slti/sltiu, 000 otherwise. ALUOp[3]=OpCode[0]. Bits above 3 are 0.
REQ-032 Wait counter: 3 bits; cleared on entry to every memory state; no wrap-around. With MEM_WAIT=0, memory states last exactly one cycle.
REQ-033 Strobes that are not active in a state SHALL be 0. Selects that are not used SHALL be 00.
REQ-034 Latencies (MEM_WAIT=0): lw 5 cycles; sw, R-type and I-type 4; branch and jump 3; illegal 3.

Reset
REQ-035 While reset is asserted, State=FETCH, the wait counter is 0 and every output is 0. This holds even mid-access, and no write strobe is asserted in the reset cycle.
REQ-036 The first FETCH begins in the cycle after reset deasserts.

Structure
REQ-037 A shared package holds the state encoding, opcode and funct constants, and the ALUOp and select encodings.
REQ-038 One sub-module, mc_decode, provides the combinational OpCode/Funct classification used by DECODE, ExtOp and ALUOp.

Verification
REQ-039 lw with MEM_WAIT=0 → states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB; RegWrite=1 only in cycle 5.
REQ-040 sw with MEM_WAIT=3 → FETCH lasts 4 cycles with IRWrite only in the last; MEM_WR lasts 4 cycles; RegWrite never asserts.
REQ-041 beq with Zero=1 → PCWrite=1 in BRANCH; bne with Zero=1 → PCWrite=0.
REQ-042 jal → RegDst=10, MemtoReg=10, PCSource=10 in JUMP; jr → PCSource=11, RegWrite=0.
REQ-043 OpCode 3f → Illegal=1 for one cycle, no strobes, then FETCH.
REQ-044 Reset asserted during the third MEM_RD wait cycle → next State=FETCH, all outputs 0, and the counter restarts at 0.
